// File: rtl/data_skid.sv
// Two-entry valid/ready register slice. Every output is driven straight from a flop, so
// neither ready_i -> ready_o nor valid_i -> valid_o is a combinational path.
module data_skid #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [1:0]        level_o
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StBusy  = 2'd1,
        StFull  = 2'd2
    } state_e;

    state_e            r_state;
    logic              r_valid;
    logic              r_ready;
    logic [1:0]        r_level;
    logic [DATA_W-1:0] r_out;
    logic [DATA_W-1:0] r_skid;

    logic w_in;
    logic w_out;

    assign w_in  = valid_i & r_ready;
    assign w_out = r_valid & ready_i;

    // Data registers are deliberately left out of the reset branch; they only load on
    // the transitions that move a beat.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_state <= StEmpty;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_level <= 2'd0;
        end else begin
            unique case (r_state)
                StEmpty: begin
                    if (w_in) begin
                        r_state <= StBusy;
                        r_valid <= 1'b1;
                        r_level <= 2'd1;
                        r_out   <= data_i;
                    end
                end
                StBusy: begin
                    if (w_in && w_out) begin
                        r_out <= data_i;
                    end else if (w_in) begin
                        r_state <= StFull;
                        r_ready <= 1'b0;
                        r_level <= 2'd2;
                        r_skid  <= data_i;
                    end else if (w_out) begin
                        r_state <= StEmpty;
                        r_valid <= 1'b0;
                        r_level <= 2'd0;
                    end
                end
                StFull: begin
                    if (w_out) begin
                        r_state <= StBusy;
                        r_ready <= 1'b1;
                        r_level <= 2'd1;
                        r_out   <= r_skid;
                    end
                end
                default: begin
                    r_state <= StEmpty;
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                    r_level <= 2'd0;
                end
            endcase
        end
    end

    assign ready_o = r_ready;
    assign valid_o = r_valid;
    assign level_o = r_level;
    assign data_o  = r_out;

endmodule

// File: tb/tb_data_skid.sv
// Scoreboard bench for data_skid: the driver pushes accepted beats into a FIFO model, an
// independent monitor checks occupancy, flags and in-order data every cycle.
`timescale 1ns/1ps
module tb_data_skid;

    logic        clk_i = 1'b0;
    logic        srst_i = 1'b1;
    logic [31:0] data_i = '0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [31:0] data_o;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [1:0]  level_o;

    data_skid #(.DATA_W(32)) dut (
        .clk_i   (clk_i),
        .srst_i  (srst_i),
        .data_i  (data_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_o  (data_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .level_o (level_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: the slice is a FIFO of at most two beats.
    logic [31:0] exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic        mon_en = 1'b0;
    logic        in_fire;
    int          max_level;
    int          out_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; inputs change just after the rising edge.
    task automatic step(input logic s, input logic v, input logic [31:0] d, input logic r);
        srst_i  = s;
        valid_i = v;
        data_i  = d;
        ready_i = r;
        @(negedge clk_i);
        in_fire = v & ready_o & ~s;
        @(posedge clk_i);
        if (s) exp_q.delete();
        else if (in_fire) exp_q.push_back(d);
        #1;
    endtask

    // Monitor: compare visible state with the model, then retire a beat on a handshake.
    logic        prev_hold = 1'b0;
    logic [31:0] prev_data = '0;
    initial begin
        logic out_fire;
        forever begin
            @(negedge clk_i);
            out_fire = 1'b0;
            if (mon_en) begin
                chk("level", 32'(level_o), 32'(exp_q.size()));
                chk("valid", 32'(valid_o), 32'(exp_q.size() > 0));
                chk("ready", 32'(ready_o), 32'(exp_q.size() < 2));
                if (exp_q.size() > 0) chk("data_order", data_o, exp_q[0]);
                if (prev_hold) chk("data_stable", data_o, prev_data);
                if (int'(level_o) > max_level) max_level = int'(level_o);
                out_fire  = valid_o & ready_i & ~srst_i;
                prev_hold = valid_o & ~ready_i & ~srst_i;
                prev_data = data_o;
            end
            @(posedge clk_i);
            if (out_fire && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                out_cnt++;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int idx;
        int cyc;
        int acc;
        logic v;
        logic [31:0] d;

        // Reset with a beat offered: it must be dropped.
        step(1'b1, 1'b1, 32'hDEAD, 1'b1);
        step(1'b1, 1'b1, 32'hDEAD, 1'b1);
        mon_en = 1'b1;
        step(1'b0, 1'b0, 32'h0, 1'b1);

        // Single beat.
        step(1'b0, 1'b1, 32'hA5, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);

        // Streaming 1..16 with ready_i high: every offer accepted, level stays 1.
        acc = 0;
        for (int i = 1; i <= 16; i++) begin
            step(1'b0, 1'b1, 32'(i), 1'b1);
            if (in_fire) acc++;
        end
        chk("stream_accepts", 32'(acc), 32'd16);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);

        // Backpressure: beat 3 leaves at edge 3, ready_i low in cycles 4..6.
        max_level = 0;
        idx = 1;
        cyc = 0;
        while (idx <= 8 && cyc < 100) begin
            step(1'b0, 1'b1, 32'(idx), !(cyc >= 4 && cyc <= 6));
            if (in_fire) idx++;
            cyc++;
        end
        chk("bp_no_timeout", 32'(cyc < 100), 32'd1);
        chk("bp_max_level", 32'(max_level), 32'd2);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("bp_drained", 32'(exp_q.size()), 32'd0);

        // Reach FULL with 0x11 and 0x22, then reset mid-stream.
        step(1'b0, 1'b1, 32'h11, 1'b0);
        step(1'b0, 1'b1, 32'h22, 1'b0);
        chk("full_level", 32'(level_o), 32'd2);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        chk("rst_valid", 32'(valid_o), 32'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Random traffic: 10k accepted beats, independent 50% valid and ready.
        acc = 0;
        cyc = 0;
        v = 1'b0;
        d = '0;
        while (acc < 10000 && cyc < 60000) begin
            v = 1'($urandom_range(0, 1));
            d = $urandom;
            step(1'b0, v, d, 1'($urandom_range(0, 1)));
            if (in_fire) acc++;
            cyc++;
        end
        chk("rand_no_timeout", 32'(acc), 32'd10000);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("final_empty", 32'(exp_q.size()), 32'd0);
        chk("final_valid", 32'(valid_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
